// File: rtl/c3lib_mtie_strap_pkg.sv
// Shared types and helpers for the metal-tie strap capture block.
package c3lib_mtie_strap_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } strap_state_e;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/c3lib_mtie_strap_cmp.sv
// Agreement counter: counts consecutive samples equal to the reference.
module c3lib_mtie_strap_cmp
  import c3lib_mtie_strap_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int N_SAMPLES = 3,
  localparam int MCW       = cnt_w(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] ref_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [MCW-1:0]   match_cnt_o,
  output logic             mismatch_o
);

  logic [MCW-1:0] cnt_q, cnt_d;

  // clear_i coincides with loading the reference, which is itself sample one.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = MCW'(1);
    else if (en_i && (sample_i == ref_i) && (cnt_q < MCW'(N_SAMPLES)))
      cnt_d = cnt_q + MCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt_o = cnt_q;
  assign mismatch_o  = en_i && (sample_i != ref_i);

endmodule

// File: rtl/c3lib_mtie_strap_capture.sv
// Settles, multi-samples and latches ECO tie-cell straps, with SW override.
// Optional even-parity check on the captured value: C3LIB_MTIE_STRAP_PARITY_EN.
module c3lib_mtie_strap_capture
  import c3lib_mtie_strap_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int N_SAMPLES  = 3,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             recap_req,
  input  logic             ovrd_en,
  input  logic [WIDTH-1:0] ovrd_val,
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
  input  logic             strap_par_in,
`endif
  output logic [WIDTH-1:0] strap_out,
  output logic             strap_valid,
  output logic             strap_err,
  output logic             busy
);

  localparam int SCW = cnt_w(SETTLE_CYC);
  localparam int RCW = cnt_w(MAX_RETRY);
  localparam int MCW = cnt_w(N_SAMPLES);
  localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE_CYC - 1);

  strap_state_e     state_q, state_d;
  logic [SCW-1:0]   set_cnt_q, set_cnt_d;
  logic [RCW-1:0]   retry_q, retry_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             cmp_clr;
  logic [MCW-1:0]   match_cnt;
  logic             mismatch;

  c3lib_mtie_strap_cmp #(.WIDTH(WIDTH), .N_SAMPLES(N_SAMPLES)) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == SAMPLE),
    .clear_i    (cmp_clr),
    .ref_i      (ref_q),
    .sample_i   (strap_in),
    .match_cnt_o(match_cnt),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    retry_d   = retry_q;
    ref_d     = ref_q;
    cap_d     = cap_q;
    valid_d   = valid_q;
    err_d     = err_q;
    cmp_clr   = 1'b0;
    case (state_q)
      SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d   = SAMPLE;
          set_cnt_d = '0;
          ref_d     = strap_in;
          cmp_clr   = 1'b1;
        end else if (set_cnt_q < SET_LAST) begin
          set_cnt_d = set_cnt_q + SCW'(1);
        end
      end
      SAMPLE: begin
        // Full agreement is checked first; the current cycle's sample is surplus.
        if (match_cnt == MCW'(N_SAMPLES)) begin
          cap_d   = ref_q;
          valid_d = 1'b1;
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
          if ((^ref_q) != strap_par_in) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else if (mismatch) begin
          if (retry_q < RCW'(MAX_RETRY)) begin
            retry_d   = retry_q + RCW'(1);
            state_d   = SETTLE;
            set_cnt_d = '0;
          end else begin
            state_d = ERR;
            cap_d   = strap_in;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Recapture overrides everything, including a same-cycle DONE entry.
    if (recap_req) begin
      state_d   = SETTLE;
      set_cnt_d = '0;
      retry_d   = '0;
      cap_d     = cap_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SETTLE;
      set_cnt_q <= '0;
      retry_q   <= '0;
      ref_q     <= '0;
      cap_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      retry_q   <= retry_d;
      ref_q     <= ref_d;
      cap_q     <= cap_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign strap_out   = ovrd_en ? ovrd_val : cap_q;
  assign strap_valid = valid_q | ovrd_en;
  assign strap_err   = err_q;
  assign busy        = (state_q == SETTLE) || (state_q == SAMPLE);

endmodule

// File: tb/tb_c3lib_mtie_strap_capture.sv
// Bench for c3lib_mtie_strap_capture: vector table, directed corners, random vs model.
module tb_c3lib_mtie_strap_capture;

  localparam int SC = 4;
  localparam int NS = 3;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] strap_in = '0;
  logic       recap_req = 1'b0;
  logic       ovrd_en = 1'b0;
  logic [7:0] ovrd_val = '0;
  logic [7:0] strap_out;
  logic       strap_valid, strap_err, busy;
  logic       par_bad = 1'b0;
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
  logic       strap_par_in;
  assign strap_par_in = (^strap_in) ^ par_bad;
`endif

  c3lib_mtie_strap_capture #(.WIDTH(8), .SETTLE_CYC(SC), .N_SAMPLES(NS), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strap_in   (strap_in),
    .recap_req  (recap_req),
    .ovrd_en    (ovrd_en),
    .ovrd_val   (ovrd_val),
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
    .strap_par_in(strap_par_in),
`endif
    .strap_out  (strap_out),
    .strap_valid(strap_valid),
    .strap_err  (strap_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 waiting, 1 collecting, 2 locked, 3 failed.
  int         m_phase, m_wait, m_got, m_retries;
  logic [7:0] m_ref, m_cap;
  logic       m_valid, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = SC; m_got = 0; m_retries = 0;
    m_ref = '0; m_cap = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] s, input logic rq, input logic pb);
    if (rq) begin
      m_phase = 0; m_wait = SC; m_retries = 0; m_valid = 1'b0; m_err = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        m_wait--;
        if (m_wait == 0) begin m_phase = 1; m_ref = s; m_got = 1; end
      end
      1: begin
        if (m_got == NS) begin
          m_phase = 2; m_cap = m_ref; m_valid = 1'b1;
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
          if ((^m_ref) != ((^s) ^ pb)) begin m_phase = 3; m_err = 1'b1; end
`endif
        end else if (s == m_ref) begin
          m_got++;
        end else if (m_retries < MR) begin
          m_retries++; m_phase = 0; m_wait = SC;
        end else begin
          m_phase = 3; m_cap = s; m_valid = 1'b1; m_err = 1'b1;
        end
      end
      default: ;
    endcase
    if (pb) ;
  endtask

  task automatic tick(input logic [7:0] s, input logic rq, input logic oe, input logic [7:0] ov);
    strap_in = s; recap_req = rq; ovrd_en = oe; ovrd_val = ov;
    @(posedge clk);
    model_step(s, rq, par_bad);
    #1;
    chk("model_out",   {24'd0, strap_out}, {24'd0, (oe ? ov : m_cap)});
    chk("model_valid", {31'd0, strap_valid}, {31'd0, (m_valid | oe)});
    chk("model_err",   {31'd0, strap_err}, {31'd0, m_err});
    chk("model_busy",  {31'd0, busy}, {31'd0, logic'(m_phase < 2)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; recap_req = 1'b0; ovrd_en = 1'b0; par_bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   {24'd0, strap_out}, 32'd0);
    chk("rst_valid", {31'd0, strap_valid}, 32'd0);
    chk("rst_err",   {31'd0, strap_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] strap;
    logic       rq;
    logic       oe;
    logic [7:0] ov;
    logic [7:0] e_out;
    logic       e_valid;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] cur;
    logic oe_r;
    // Stable A5 from reset: valid on the 7th edge, then a recapture-wins row.
    for (int i = 0; i < 6; i++) tbl[i] = '{8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'h11, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h11, 1'b0, 1'b1, 8'h77, 8'h77, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{8'h3C, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].strap, tbl[i].rq, tbl[i].oe, tbl[i].ov);
      chk($sformatf("tbl%0d_out", i),   {24'd0, strap_out}, {24'd0, tbl[i].e_out});
      chk($sformatf("tbl%0d_valid", i), {31'd0, strap_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_err", i),   {31'd0, strap_err}, {31'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end
    // Recapture with 3C: old value held, new one valid on the 7th edge after.
    for (int i = 1; i <= 7; i++) begin
      tick(8'h3C, 1'b0, 1'b0, 8'h00);
      if (i == 6) chk("recap_hold_valid", {31'd0, strap_valid}, 32'd0);
      if (i == 6) chk("recap_hold_out", {24'd0, strap_out}, 32'hA5);
    end
    chk("recap_new_out", {24'd0, strap_out}, 32'h3C);
    chk("recap_new_valid", {31'd0, strap_valid}, 32'd1);

    // Single-cycle glitch during sampling costs one retry.
    do_reset();
    for (int i = 1; i <= 4; i++) tick(8'hA5, 1'b0, 1'b0, 8'h00);
    tick(8'hA4, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) tick(8'hA5, 1'b0, 1'b0, 8'h00);
    chk("glitch_not_yet", {31'd0, strap_valid}, 32'd0);
    tick(8'hA5, 1'b0, 1'b0, 8'h00);
    chk("glitch_valid", {31'd0, strap_valid}, 32'd1);
    chk("glitch_out", {24'd0, strap_out}, 32'hA5);
    chk("glitch_err", {31'd0, strap_err}, 32'd0);

    // Alternating straps exhaust the retry budget on the 15th edge.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick((k % 2) ? 8'hA5 : 8'hA4, 1'b0, 1'b0, 8'h00);
      if (k == 14) chk("alt_err_early", {31'd0, strap_err}, 32'd0);
      if (k == 15) begin
        chk("alt_err", {31'd0, strap_err}, 32'd1);
        chk("alt_valid", {31'd0, strap_valid}, 32'd1);
        chk("alt_out", {24'd0, strap_out}, 32'hA5);
      end
    end
    chk("alt_hold_out", {24'd0, strap_out}, 32'hA5);
    chk("alt_hold_busy", {31'd0, busy}, 32'd0);

    // Override in SETTLE, then released before capture completes.
    do_reset();
    tick(8'h5A, 1'b0, 1'b1, 8'hFF);
    chk("ovrd_out", {24'd0, strap_out}, 32'hFF);
    chk("ovrd_valid", {31'd0, strap_valid}, 32'd1);
    for (int i = 2; i <= 6; i++) tick(8'h5A, 1'b0, 1'b0, 8'hFF);
    chk("ovrd_off_valid", {31'd0, strap_valid}, 32'd0);
    tick(8'h5A, 1'b0, 1'b0, 8'hFF);
    chk("ovrd_done_out", {24'd0, strap_out}, 32'h5A);

`ifdef C3LIB_MTIE_STRAP_PARITY_EN
    do_reset();
    par_bad = 1'b1;
    for (int i = 0; i < 7; i++) tick(8'h01, 1'b0, 1'b0, 8'h00);
    chk("par_bad_err", {31'd0, strap_err}, 32'd1);
    chk("par_bad_out", {24'd0, strap_out}, 32'h01);
    do_reset();
    for (int i = 0; i < 7; i++) tick(8'h01, 1'b0, 1'b0, 8'h00);
    chk("par_ok_err", {31'd0, strap_err}, 32'd0);
    chk("par_ok_valid", {31'd0, strap_valid}, 32'd1);
`endif

    // Random traffic against the model, with one mid-run reset.
    do_reset();
    cur = 8'hA5; oe_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) cur = 8'($urandom);
      if ($urandom_range(0, 19) == 0) oe_r = ~oe_r;
`ifdef C3LIB_MTIE_STRAP_PARITY_EN
      par_bad = ($urandom_range(0, 7) == 0);
`endif
      tick(cur, $urandom_range(0, 59) == 0, oe_r, 8'($urandom));
      if (i == 700) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
